// File: rtl/spart_echo_driver.sv
// Drives a SPART over its register bus: programs the baud divisor, then echoes received bytes back through a small FIFO.
// Optional build macro ECHO_CASE_SWAP_EN flips the case of ASCII letters on the way back out.
module spart_echo_driver #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    output logic       iocs,
    output logic       iorw,
    input  logic       rda,
    input  logic       tbr,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       init_done,
    output logic       fifo_full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        INIT_LO,
        INIT_HI,
        IDLE,
        RD_RX,
        WR_TX,
        GAP
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    state_t        arb_next;
    logic          run_reg;
    logic          init_done_reg;
    logic [1:0]    prog_cfg_reg;
    logic          cfg_dirty_reg;
    logic          cfg_pending;
    logic          start_init;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [7:0]    head_reg;
    logic [7:0]    tx_byte;
    logic [7:0]    bus_out;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full_w;
    logic [15:0]   div_tab [4];
    logic [15:0]   divisor;

    // Divisor for 4800 << gi baud, one entry per br_cfg code.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_div
            localparam int BAUD = 4800 << gi;
            assign div_tab[gi] = 16'(CLK_HZ / (16 * BAUD) - 1);
        end
    endgenerate

    assign divisor     = div_tab[prog_cfg_reg];
    assign cfg_pending = cfg_dirty_reg | (br_cfg != prog_cfg_reg);

    assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full_w = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

`ifdef ECHO_CASE_SWAP_EN
    logic is_letter;
    assign is_letter = ((head_reg >= 8'h41) && (head_reg <= 8'h5A)) ||
                       ((head_reg >= 8'h61) && (head_reg <= 8'h7A));
    assign tx_byte   = is_letter ? (head_reg ^ 8'h20) : head_reg;
`else
    assign tx_byte   = head_reg;
`endif

    // Idle arbitration; GAP falls straight through it so accesses can run every other cycle.
    always_comb begin
        arb_next = IDLE;
        if (cfg_pending)
            arb_next = INIT_LO;
        else if (rda && !fifo_full_w)
            arb_next = RD_RX;
        else if (tbr && !fifo_empty)
            arb_next = WR_TX;
    end

    always_comb begin
        state_next = state_reg;
        iocs       = 1'b0;
        iorw       = 1'b1;
        ioaddr     = 2'b01;
        bus_out    = 8'h00;
        push       = 1'b0;
        pop        = 1'b0;
        start_init = 1'b0;
        case (state_reg)
            INIT_LO: begin
                // run_reg holds off the first write until the edge after reset release.
                if (run_reg) begin
                    iocs       = 1'b1;
                    iorw       = 1'b0;
                    ioaddr     = 2'b10;
                    bus_out    = divisor[7:0];
                    state_next = INIT_HI;
                end
            end
            INIT_HI: begin
                iocs       = 1'b1;
                iorw       = 1'b0;
                ioaddr     = 2'b11;
                bus_out    = divisor[15:8];
                state_next = GAP;
            end
            IDLE, GAP: begin
                state_next = arb_next;
                start_init = (arb_next == INIT_LO);
            end
            RD_RX: begin
                iocs       = 1'b1;
                iorw       = 1'b1;
                ioaddr     = 2'b00;
                push       = 1'b1;
                state_next = GAP;
            end
            WR_TX: begin
                iocs       = 1'b1;
                iorw       = 1'b0;
                ioaddr     = 2'b00;
                bus_out    = tx_byte;
                pop        = 1'b1;
                state_next = GAP;
            end
            default: state_next = INIT_LO;
        endcase
    end

    assign databus = (iocs && !iorw) ? bus_out : 8'hzz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= INIT_LO;
            run_reg       <= 1'b0;
            init_done_reg <= 1'b0;
            prog_cfg_reg  <= br_cfg;
            cfg_dirty_reg <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
            if (start_init)
                init_done_reg <= 1'b0;
            else if (state_reg == INIT_HI)
                init_done_reg <= 1'b1;
            // Latch the code being programmed; any later change stays pending until the next idle.
            if (start_init) begin
                prog_cfg_reg  <= br_cfg;
                cfg_dirty_reg <= 1'b0;
            end else if (br_cfg != prog_cfg_reg) begin
                cfg_dirty_reg <= 1'b1;
            end
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    // Registered head read: every WR_TX is preceded by at least one idle/gap cycle that refreshes it.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg[AW-1:0]] <= databus;
        head_reg <= mem[rd_ptr_reg[AW-1:0]];
    end

    assign init_done = init_done_reg;
    assign fifo_full = fifo_full_w;

endmodule

// File: tb/tb_spart_echo_driver.sv
// Directed bench for spart_echo_driver: models the SPART side of the bus and checks each access cycle.
module tb_spart_echo_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b01;
    logic       rda = 1'b0;
    logic       tbr = 1'b0;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       init_done;
    logic       fifo_full;
    wire  [7:0] databus;
    logic [7:0] rx_byte = 8'h00;
    logic       probe = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // SPART side: drives read data, or a probe value used to prove the DUT has released the bus.
    assign databus = ((iocs && iorw) || probe) ? rx_byte : 8'hzz;

    spart_echo_driver #(.CLK_HZ(50_000_000), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .iocs(iocs), .iorw(iorw),
        .rda(rda), .tbr(tbr), .ioaddr(ioaddr), .databus(databus),
        .init_done(init_done), .fifo_full(fifo_full)
    );

    always @(negedge clk)
        if (iocs)
            $display("bus %s addr=%b data=%02h", iorw ? "rd" : "wr", ioaddr, databus);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; br_cfg = 2'b01; probe = 1'b1; rx_byte = 8'h00;
        tick();
        tick();
        checks++; if ({iocs, iorw, ioaddr} !== 4'b0101) begin errors++; $display("FAIL reset_ctl: got %b expected 0101", {iocs, iorw, ioaddr}); end
        checks++; if ({init_done, fifo_full} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {init_done, fifo_full}); end
        checks++; if (databus !== 8'h00) begin errors++; $display("FAIL reset_bus_released: got %02h expected 00", databus); end
        probe = 1'b0;
        rst = 1'b0;
        tick();
        checks++; if ({iocs, iorw, ioaddr} !== 4'b1010) begin errors++; $display("FAIL init_lo_ctl: got %b expected 1010", {iocs, iorw, ioaddr}); end
        checks++; if (databus !== 8'h44) begin errors++; $display("FAIL init_lo_data: got %02h expected 44", databus); end
        tick();
        checks++; if ({iocs, iorw, ioaddr} !== 4'b1011) begin errors++; $display("FAIL init_hi_ctl: got %b expected 1011", {iocs, iorw, ioaddr}); end
        checks++; if (databus !== 8'h01) begin errors++; $display("FAIL init_hi_data: got %02h expected 01", databus); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early: got %b expected 0", init_done); end
        tick();
        checks++; if ({iocs, init_done} !== 2'b01) begin errors++; $display("FAIL init_gap: got iocs,init_done=%b expected 01", {iocs, init_done}); end
        tick();
        checks++; if ({iocs, iorw, ioaddr, init_done} !== 5'b01011) begin errors++; $display("FAIL idle_ctl: got %b expected 01011", {iocs, iorw, ioaddr, init_done}); end
    endtask

    task automatic test_echo();
        logic [7:0] exp_tx;
`ifdef ECHO_CASE_SWAP_EN
        exp_tx = 8'h7A;
`else
        exp_tx = 8'h5A;
`endif
        rda = 1'b1; rx_byte = 8'h5A; tbr = 1'b1;
        tick();
        checks++; if ({iocs, iorw, ioaddr} !== 4'b1100) begin errors++; $display("FAIL echo_rd_ctl: got %b expected 1100", {iocs, iorw, ioaddr}); end
        rda = 1'b0;
        tick();
        checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL echo_gap: got iocs=%b expected 0", iocs); end
        tick();
        checks++; if ({iocs, iorw, ioaddr} !== 4'b1000) begin errors++; $display("FAIL echo_wr_ctl: got %b expected 1000", {iocs, iorw, ioaddr}); end
        checks++; if (databus !== exp_tx) begin errors++; $display("FAIL echo_wr_data: got %02h expected %02h", databus, exp_tx); end
        tbr = 1'b0;
        tick();
        tick();
        checks++; if ({iocs, fifo_full} !== 2'b00) begin errors++; $display("FAIL echo_idle: got %b expected 00", {iocs, fifo_full}); end
    endtask

    task automatic test_fifo_full();
        tbr = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            rda = 1'b1; rx_byte = 8'(i);
            tick();
            checks++; if ({iocs, iorw, ioaddr} !== 4'b1100) begin errors++; $display("FAIL fill_rd_%0d: got %b expected 1100", i, {iocs, iorw, ioaddr}); end
            rda = 1'b0;
            tick();
        end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fifo_full_set: got %b expected 1", fifo_full); end
        rda = 1'b1; rx_byte = 8'h09;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL full_rda_ignored_%0d: got iocs=%b expected 0", i, iocs); end
        end
        rda = 1'b0; tbr = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++; if ({iocs, iorw, ioaddr} !== 4'b1000 || databus !== 8'(i)) begin errors++; $display("FAIL drain_%0d: got ctl=%b data=%02h expected ctl=1000 data=%02h", i, {iocs, iorw, ioaddr}, databus, 8'(i)); end
            tick();
            checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL drain_gap_%0d: got iocs=%b expected 0", i, iocs); end
        end
        tick();
        checks++; if ({iocs, fifo_full} !== 2'b00) begin errors++; $display("FAIL drain_empty: got %b expected 00", {iocs, fifo_full}); end
        tbr = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        rda = 1'b1; rx_byte = 8'h33; tbr = 1'b0;
        tick();
        rda = 1'b0;
        tick();
        tick();
        rda = 1'b1; rx_byte = 8'h44; tbr = 1'b1;
        tick();
        checks++; if ({iocs, iorw, ioaddr} !== 4'b1100) begin errors++; $display("FAIL prio_rd_first: got %b expected 1100", {iocs, iorw, ioaddr}); end
        rda = 1'b0;
        tick();
        tick();
        checks++; if ({iocs, iorw} !== 2'b10 || databus !== 8'h33) begin errors++; $display("FAIL prio_wr1: got ctl=%b data=%02h expected 10/33", {iocs, iorw}, databus); end
        tick();
        tick();
        checks++; if ({iocs, iorw} !== 2'b10 || databus !== 8'h44) begin errors++; $display("FAIL prio_wr2: got ctl=%b data=%02h expected 10/44", {iocs, iorw}, databus); end
        tbr = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reprogram();
        logic [7:0] bytes [3];
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
        tbr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rda = 1'b1; rx_byte = bytes[i];
            tick();
            rda = 1'b0;
            tick();
        end
        br_cfg = 2'b11;
        tick();
        checks++; if ({iocs, iorw, ioaddr} !== 4'b1010 || databus !== 8'h50) begin errors++; $display("FAIL reprog_lo: got ctl=%b data=%02h expected 1010/50", {iocs, iorw, ioaddr}, databus); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reprog_init_done_clr: got %b expected 0", init_done); end
        tick();
        checks++; if ({iocs, iorw, ioaddr} !== 4'b1011 || databus !== 8'h00) begin errors++; $display("FAIL reprog_hi: got ctl=%b data=%02h expected 1011/00", {iocs, iorw, ioaddr}, databus); end
        tbr = 1'b1;
        tick();
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL reprog_init_done_set: got %b expected 1", init_done); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({iocs, iorw, ioaddr} !== 4'b1000 || databus !== bytes[i]) begin errors++; $display("FAIL reprog_echo_%0d: got ctl=%b data=%02h expected 1000/%02h", i, {iocs, iorw, ioaddr}, databus, bytes[i]); end
            tick();
        end
        tbr = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        rda = 1'b1; rx_byte = 8'h77; tbr = 1'b0;
        tick();
        rda = 1'b0;
        tick();
        tbr = 1'b1;
        tick();
        checks++; if ({iocs, iorw} !== 2'b10 || databus !== 8'h77) begin errors++; $display("FAIL mid_wr: got ctl=%b data=%02h expected 10/77", {iocs, iorw}, databus); end
        rst = 1'b1; probe = 1'b1; rx_byte = 8'h00;
        #1;
        checks++; if ({iocs, iorw, ioaddr, fifo_full} !== 5'b01010) begin errors++; $display("FAIL mid_rst_ctl: got %b expected 01010", {iocs, iorw, ioaddr, fifo_full}); end
        checks++; if (databus !== 8'h00) begin errors++; $display("FAIL mid_rst_bus_released: got %02h expected 00", databus); end
        tick();
        probe = 1'b0;
        rst = 1'b0;
        tick();
        checks++; if ({iocs, iorw, ioaddr} !== 4'b1010 || databus !== 8'h50) begin errors++; $display("FAIL reinit_lo: got ctl=%b data=%02h expected 1010/50", {iocs, iorw, ioaddr}, databus); end
        tick();
        tick();
        tick();
        checks++; if ({iocs, iorw, ioaddr} !== 4'b0101) begin errors++; $display("FAIL reinit_fifo_empty: got %b expected 0101", {iocs, iorw, ioaddr}); end
        tbr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_echo();
        test_fifo_full();
        test_back_to_back();
        test_reprogram();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
